// File: rtl/flappy_pkg.sv
// Shared constants and helpers for the flappy-bird game core.
package flappy_pkg;

   localparam int         ROWS      = 8;
   // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a shift-left register: b7^b5^b4^b3.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam int         GAP_H     = 3;

   // Mask with gap_h consecutive ones starting at row gap_low (rows off the top are dropped).
   function automatic logic [ROWS-1:0] gap_mask(input logic [2:0] gap_low, input int gap_h);
      logic [ROWS-1:0] m;
      m = '0;
      for (int i = 0; i < ROWS; i++) begin
         if ((i >= int'(gap_low)) && (i < int'(gap_low) + gap_h)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // Fold a 3-bit random value into 0..5 so a 3-row gap always fits in 8 rows.
   function automatic logic [2:0] fold_gap_low(input logic [2:0] raw);
      logic [2:0] g;
      if (raw < 3'd6) begin
         g = raw;
      end else begin
         g = raw - 3'd4;
      end
      return g;
   endfunction

endpackage

// File: rtl/flappy_if.sv
// Game-side signal bundle: bird/pipe inputs from the matrix, timing and scoring outputs.
interface flappy_if;
   import flappy_pkg::*;

   logic [ROWS-1:0] bird_pos;
   logic [ROWS-1:0] pipe_col;
   logic [31:0]     divided_clocks;
   logic            tick;
   logic [ROWS-1:0] pattern;
   logic            lose;
   logic            pass;

   modport master (
      output bird_pos, pipe_col,
      input  divided_clocks, tick, pattern, lose, pass
   );

   modport slave (
      input  bird_pos, pipe_col,
      output divided_clocks, tick, pattern, lose, pass
   );
endinterface

// File: rtl/flappy_game_core_clock_div_counter.sv
// Free-running 32-bit divider counter with a single-cycle game-step tick decode.
module clock_div_counter #(
   parameter int TICK_BIT = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_en,
   output logic [31:0] count,
   output logic        tick
);

   // Pattern {1, TICK_BIT zeros}: the rising transition of bit TICK_BIT.
   localparam logic [TICK_BIT:0] TICK_MATCH = {{TICK_BIT{1'b0}}, 1'b1} << TICK_BIT;

   logic [31:0] count_r;

   // Counter advances every clock and wraps naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= 32'd0;
      end else begin
         count_r <= count_r + 32'd1;
      end
   end

   // Tick decode is combinational so it lines up with the counter value.
   always_comb begin
      tick = 1'b0;
      if (tick_en && (count_r[TICK_BIT:0] == TICK_MATCH)) begin
         tick = 1'b1;
      end else begin
         tick = 1'b0;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/flappy_game_core.sv
// Flappy-bird core: timing, pipe column generation, collision and scoring.
module flappy_game_core
   import flappy_pkg::*;
#(
   parameter int         TICK_BIT    = 20,
   parameter int         PIPE_PERIOD = 4,
   parameter int         GAP_H       = 3,
   parameter logic [7:0] LFSR_SEED   = flappy_pkg::LFSR_SEED
) (
   input  logic     clk,
   input  logic     reset,
   flappy_if.slave  bus
);

   localparam int            CNT_W    = (PIPE_PERIOD > 1) ? $clog2(PIPE_PERIOD) : 1;
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(PIPE_PERIOD - 1);

   logic [31:0]      div_count;
   logic             tick;
   logic [7:0]       lfsr_r, lfsr_nxt;
   logic [CNT_W-1:0] col_r, col_nxt;
   logic [ROWS-1:0]  pattern_r, pattern_nxt;
   logic [ROWS-1:0]  pipe_col_prev_r;
   logic             lose_r, lose_nxt;
   logic             pass_r, pass_nxt;
   logic             hit;
   logic             lfsr_fb;
   logic [2:0]       gap_low;

   // Ticks stop once the game is lost, which freezes everything driven by them.
   clock_div_counter #(.TICK_BIT(TICK_BIT)) u_div (
      .clk     (clk),
      .reset   (reset),
      .tick_en (!lose_r),
      .count   (div_count),
      .tick    (tick)
   );

   // Next-state logic for the pipe generator, collision flag and pass pulse.
   always_comb begin
      lfsr_nxt    = lfsr_r;
      col_nxt     = col_r;
      pattern_nxt = pattern_r;
      lfsr_fb     = ^(lfsr_r & LFSR_TAPS);
      gap_low     = fold_gap_low(lfsr_r[2:0]);
      hit         = ((bus.bird_pos & bus.pipe_col) != '0) || (bus.bird_pos == '0);
      if (tick) begin
         lfsr_nxt = {lfsr_r[6:0], lfsr_fb};
         if (col_r == COL_LAST) begin
            col_nxt = '0;
         end else begin
            col_nxt = col_r + CNT_W'(1);
         end
         if (col_r == '0) begin
            pattern_nxt = 8'hFF & ~gap_mask(gap_low, GAP_H);
         end else begin
            pattern_nxt = 8'h00;
         end
      end else begin
         lfsr_nxt    = lfsr_r;
         col_nxt     = col_r;
         pattern_nxt = pattern_r;
      end
      lose_nxt = lose_r | hit;
      // A hit in the same cycle as a clean pass suppresses the pass.
      pass_nxt = !lose_r && !hit && (pipe_col_prev_r != '0) && (bus.pipe_col == '0);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_r          <= LFSR_SEED;
         col_r           <= '0;
         pattern_r       <= '0;
         pipe_col_prev_r <= '0;
         lose_r          <= 1'b0;
         pass_r          <= 1'b0;
      end else begin
         lfsr_r          <= lfsr_nxt;
         col_r           <= col_nxt;
         pattern_r       <= pattern_nxt;
         pipe_col_prev_r <= bus.pipe_col;
         lose_r          <= lose_nxt;
         pass_r          <= pass_nxt;
      end
   end

   assign bus.divided_clocks = div_count;
   assign bus.tick           = tick;
   assign bus.pattern        = pattern_r;
   assign bus.lose           = lose_r;
   assign bus.pass           = pass_r;

endmodule

// File: tb/tb_flappy_game_core.sv
// Directed self-checking bench for flappy_game_core with TICK_BIT=2.
module tb_flappy_game_core;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   tick_num;
   logic [7:0]  p0;
   logic [31:0] c0;

   flappy_if bus ();

   flappy_game_core #(.TICK_BIT(2), .PIPE_PERIOD(4), .GAP_H(3), .LFSR_SEED(8'hA5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Advance until tick is seen (bounded), then clock it in.
   task automatic wait_tick();
      int n;
      n = 0;
      while (!bus.tick && n < 32) begin
         step();
         n++;
      end
      check("tick_seen", {31'd0, bus.tick}, 32'd1);
      step();
      tick_num++;
   endtask

   // Pipe column must have exactly three contiguous zeros starting at row 0..5.
   task automatic check_pipe_shape();
      logic [7:0] inv;
      logic [7:0] want;
      int gl;
      inv = ~bus.pattern;
      gl = 8;
      for (int i = 7; i >= 0; i--) begin
         if (inv[i]) gl = i;
      end
      want = 8'(8'h07 << gl);
      check("gap_shape", {24'd0, inv}, {24'd0, want});
      check("gap_range", {31'd0, (gl <= 5)}, 32'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      tick_num = 0;
      reset        = 1'b0;
      bus.bird_pos = 8'h01;
      bus.pipe_col = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_count",   bus.divided_clocks, 32'd0);
      check("rst_pattern", {24'd0, bus.pattern}, 32'h00);
      check("rst_lose",    {31'd0, bus.lose}, 32'd0);
      check("rst_pass",    {31'd0, bus.pass}, 32'd0);
      reset = 1'b1;

      // Counter 0..15, ticks only at 4 and 12, first pipe column 1F.
      for (int i = 0; i < 16; i++) begin
         check("count_seq", bus.divided_clocks, 32'(i));
         check("tick_pos",  {31'd0, bus.tick}, {31'd0, (i == 4 || i == 12)});
         check("pat_early", {24'd0, bus.pattern},
               (i <= 4) ? 32'h00 : ((i <= 12) ? 32'h1F : 32'h00));
         check("lose_early", {31'd0, bus.lose}, 32'd0);
         check("pass_early", {31'd0, bus.pass}, 32'd0);
         step();
      end
      tick_num = 2;

      wait_tick();
      check("tick3_pat", {24'd0, bus.pattern}, 32'h00);
      wait_tick();
      check("tick4_pat", {24'd0, bus.pattern}, 32'h00);
      wait_tick();
      check("tick5_pat", {24'd0, bus.pattern}, 32'h8F);

      // Long run: every fourth column is a pipe with a valid gap.
      for (int k = 0; k < 1000; k++) begin
         wait_tick();
         if (((tick_num - 1) % 4) == 0) begin
            check_pipe_shape();
         end else begin
            check("empty_col", {24'd0, bus.pattern}, 32'h00);
         end
      end

      // Collision: bird row overlaps a green pixel.
      bus.bird_pos = 8'h10;
      bus.pipe_col = 8'h10;
      step();
      check("hit_lose", {31'd0, bus.lose}, 32'd1);
      check("hit_pass", {31'd0, bus.pass}, 32'd0);
      p0 = bus.pattern;
      c0 = bus.divided_clocks;
      bus.pipe_col = 8'h00;
      for (int i = 0; i < 20; i++) begin
         check("frozen_tick", {31'd0, bus.tick}, 32'd0);
         step();
      end
      check("frozen_pat",  {24'd0, bus.pattern}, {24'd0, p0});
      check("count_runs",  bus.divided_clocks, c0 + 32'd20);
      check("lose_sticky", {31'd0, bus.lose}, 32'd1);

      // Asynchronous reset mid-cycle.
      #2 reset = 1'b0;
      #1;
      check("arst_count",   bus.divided_clocks, 32'd0);
      check("arst_pattern", {24'd0, bus.pattern}, 32'h00);
      check("arst_lose",    {31'd0, bus.lose}, 32'd0);
      check("arst_pass",    {31'd0, bus.pass}, 32'd0);
      bus.bird_pos = 8'h10;
      bus.pipe_col = 8'hE3;
      @(negedge clk);
      reset = 1'b1;

      // Pipe passes the bird without touching it; tick timing restarts.
      for (int i = 0; i < 6; i++) begin
         check("re_count", bus.divided_clocks, 32'(i));
         check("re_tick",  {31'd0, bus.tick}, {31'd0, (i == 4)});
         check("re_pass",  {31'd0, bus.pass}, 32'd0);
         check("re_lose",  {31'd0, bus.lose}, 32'd0);
         step();
      end
      check("re_pat", {24'd0, bus.pattern}, 32'h1F);
      bus.pipe_col = 8'h00;
      step();
      check("pass_pulse", {31'd0, bus.pass}, 32'd1);
      check("pass_lose",  {31'd0, bus.lose}, 32'd0);
      step();
      check("pass_end",   {31'd0, bus.pass}, 32'd0);

      // Bird leaves the screen exactly as a pass would happen: lose wins.
      bus.pipe_col = 8'hE3;
      step();
      step();
      bus.pipe_col = 8'h00;
      bus.bird_pos = 8'h00;
      step();
      check("off_lose", {31'd0, bus.lose}, 32'd1);
      check("off_pass", {31'd0, bus.pass}, 32'd0);
      step();
      check("off_pass2", {31'd0, bus.pass}, 32'd0);

      #2 reset = 1'b0;
      #1;
      check("arst2_lose",  {31'd0, bus.lose}, 32'd0);
      check("arst2_count", bus.divided_clocks, 32'd0);
      check("arst2_pass",  {31'd0, bus.pass}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flappy_game_core.md
Name: flappy_game_core

Overview:
- Timing, pipe-generation and scoring core of the 8x8 LED-matrix flappy-bird game.
- Provides a free-running clock-divider counter and a game-step tick.
- Generates one new 8-row pipe column per tick; matrix shifting is external.
- Detects collisions with the bird (sticky lose) and successful pipe passes (pass pulse).

Parameters:
- TICK_BIT, 20, divider bit whose rising transition produces the game-step tick (sim uses 2).
- PIPE_PERIOD, 4, columns per pipe cycle: one pipe column followed by PIPE_PERIOD-1 empty columns.
- GAP_H, 3, height in rows of the opening in each pipe.
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero.

Ports:
- clk  in  1  single system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- bird_pos  in  8  one-hot bird row in the bird column (bit0 = bottom row).
- pipe_col  in  8  green pixels currently in the bird column.
- divided_clocks  out  32  free-running counter; bit n toggles at clk/2^(n+1).
- tick  out  1  one-cycle game-step pulse.
- pattern  out  8  next pipe column to inject at the right edge; 1 = green pixel.
- lose  out  1  sticky collision flag.
- pass  out  1  one-cycle pulse per pipe cleared.

Behaviour:
- Reset (async, while reset=0):
  - divided_clocks=0, pattern=0, lose=0, pass=0.
  - LFSR=LFSR_SEED, column counter=0, pipe_col_prev=0.
- divided_clocks:
  - Increments by 1 every clk, wraps 2^32-1 -> 0.
  - Keeps running regardless of lose.
- tick:
  - Combinational: 1 when divided_clocks[TICK_BIT:0] == {1'b1, TICK_BIT zeros}.
  - Exactly one cycle high per 2^(TICK_BIT+1) clks.
  - First tick at counter value 2^TICK_BIT.
  - Forced 0 while lose=1.
- Pattern generation, on each clk where tick=1:
  - LFSR advances: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, shift left, feedback = b7^b5^b4^b3 into b0.
  - Column counter advances 0..PIPE_PERIOD-1, wrapping to 0.
  - If counter (before increment) == 0: pattern = 8'hFF with bits gap_low..gap_low+GAP_H-1 cleared.
  - gap_low = lfsr[2:0] if < 6, else lfsr[2:0]-4, using LFSR value before the advance. Range 0..5, so the gap never leaves the matrix.
  - Otherwise: pattern = 8'h00.
  - Between ticks, pattern holds.
- Collision:
  - hit = (bird_pos & pipe_col) != 0, or bird_pos == 0 (bird off-screen).
  - lose is registered: set on the clk edge after hit is seen.
  - Once set, lose stays 1 until reset; pattern, LFSR and column counter freeze.
- Pass:
  - pipe_col_prev registers pipe_col every clk.
  - pass=1 for exactly one clk when pipe_col_prev != 0, pipe_col == 0, lose=0 and hit=0.
  - Registered output, latency 1 clk.
  - If hit and pass conditions coincide, lose wins and pass stays 0.
- Reset mid-game: asynchronous return to reset values; first tick recurs after 2^TICK_BIT clks.

Decomposition:
- Shared package flappy_pkg holds:
  - ROWS=8.
  - LFSR taps and LFSR_SEED.
  - A function gap_mask(gap_low) returning the GAP_H-row cleared mask.
- One natural sub-module: clock_div_counter (32-bit counter plus tick decode).
- Pipe generation and scoring stay in the top.

Test Plan:
- Reset, then 16 clks, TICK_BIT=2 -> divided_clocks counts 0..15. tick high only at counts 4 and 12. pattern, lose and pass all 0.
- First tick after reset, LFSR=8'hA5 (lfsr[2:0]=5) -> pattern=8'h1F (gap rows 5..7). Next 3 ticks -> pattern=8'h00. 5th tick -> new pipe column.
- Drive 1000 ticks, checking each pipe column -> exactly GAP_H=3 contiguous zeros and gap_low in 0..5 for every pipe column.
- bird_pos=8'h10, pipe_col=8'h10 -> lose=1 next clk. pattern and LFSR stop changing on further ticks; lose stays 1 until reset=0.
- bird_pos=8'h10, pipe_col=8'hE3 for 3 clks, then 8'h00 -> one pass pulse on the clk after the transition, lose stays 0.
- bird_pos=8'h00 -> lose=1. Assert reset mid-game -> all outputs return to 0 immediately (asynchronous).
